// File: rtl/input_debouncer.sv
// Multi-channel input conditioner: N-stage synchroniser, stability counter, clean level and edge pulses.
// Optional long-press flag per channel when DEBOUNCE_HOLD_EN is defined; otherwise hold is tied low.
module input_debouncer #(
  parameter int unsigned       NUM_CH         = 4,
  parameter int unsigned       SYNC_STAGES    = 2,
  parameter int unsigned       DEBOUNCE_LIMIT = 1000000,
  parameter int unsigned       CNT_BITS       = $clog2(DEBOUNCE_LIMIT + 1),
  parameter logic [NUM_CH-1:0] RESET_VAL      = {NUM_CH{1'b1}},
  parameter int unsigned       HOLD_LIMIT     = 4 * DEBOUNCE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] din,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic [NUM_CH-1:0] hold
);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("input_debouncer: NUM_CH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("input_debouncer: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_LIMIT < 1) begin : g_bad_limit
    $error("input_debouncer: DEBOUNCE_LIMIT must be >= 1");
  end
  if (HOLD_LIMIT < 1) begin : g_bad_hold
    $error("input_debouncer: HOLD_LIMIT must be >= 1");
  end

  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(DEBOUNCE_LIMIT - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
  logic [CNT_BITS-1:0]    cnt    [NUM_CH];
  logic [CNT_BITS-1:0]    cnt_d  [NUM_CH];
  logic [NUM_CH-1:0]      s;
  logic [NUM_CH-1:0]      level_d;
  logic [NUM_CH-1:0]      rise_d;
  logic [NUM_CH-1:0]      fall_d;

  // Next-state is computed combinationally so the hold logic can clear on the same edge level deactivates.
  always_comb begin
    s       = '0;
    level_d = level;
    rise_d  = '0;
    fall_d  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      s[i]     = sync_q[i][SYNC_STAGES-1];
      cnt_d[i] = cnt[i];
      if (s[i] == level[i]) begin
        cnt_d[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        level_d[i] = s[i];
        cnt_d[i]   = '0;
        rise_d[i]  = s[i];
        fall_d[i]  = ~s[i];
      end else begin
        cnt_d[i] = cnt[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        sync_q[i] <= {SYNC_STAGES{RESET_VAL[i]}};
        cnt[i]    <= '0;
      end
      level <= RESET_VAL;
      rise  <= '0;
      fall  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], din[i]};
        cnt[i]    <= cnt_d[i];
      end
      level <= level_d;
      rise  <= rise_d;
      fall  <= fall_d;
    end
  end

`ifdef DEBOUNCE_HOLD_EN
  localparam int unsigned          HOLD_BITS = $clog2(HOLD_LIMIT + 1);
  localparam logic [HOLD_BITS-1:0] HOLD_MAX  = HOLD_BITS'(HOLD_LIMIT);
  localparam logic [HOLD_BITS-1:0] HOLD_LAST = HOLD_BITS'(HOLD_LIMIT - 1);
  localparam logic [HOLD_BITS-1:0] HOLD_ONE  = HOLD_BITS'(1);

  logic [HOLD_BITS-1:0] hold_cnt [NUM_CH];

  // Counting starts the edge after level turns active; the count saturates at HOLD_LIMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        hold_cnt[i] <= '0;
      end
      hold <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (level_d[i] == RESET_VAL[i]) begin
          hold_cnt[i] <= '0;
          hold[i]     <= 1'b0;
        end else if ((level[i] != RESET_VAL[i]) && (hold_cnt[i] != HOLD_MAX)) begin
          hold_cnt[i] <= hold_cnt[i] + HOLD_ONE;
          hold[i]     <= (hold_cnt[i] == HOLD_LAST);
        end
      end
    end
  end
`else
  assign hold = '0;
`endif

endmodule
